// File: rtl/stack_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : stack_arbiter
// Purpose  : Round-robin two-port arbiter and sequencer for a shared LIFO
//            stack: grants one push/pop, drives the stack, returns the result.
// Revision : 1.0 - initial release
// ============================================================================
module stack_arbiter #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqa_valid,
  input  logic              reqa_op,
  input  logic [DATA_W-1:0] reqa_wdata,
  output logic              reqa_gnt,
  output logic              respa_valid,
  input  logic              reqb_valid,
  input  logic              reqb_op,
  input  logic [DATA_W-1:0] reqb_wdata,
  output logic              reqb_gnt,
  output logic              respb_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [1:0]        resp_err,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_wdata,
  input  logic [DATA_W-1:0] stk_rdata,
  input  logic              stk_done,
  input  logic              stk_empty,
  input  logic              stk_full
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_wait  = 2'd2;
  localparam logic [1:0] c_st_resp  = 2'd3;

  localparam logic [1:0] c_err_ok      = 2'b00;
  localparam logic [1:0] c_err_full    = 2'b01;
  localparam logic [1:0] c_err_empty   = 2'b10;
  localparam logic [1:0] c_err_timeout = 2'b11;

  localparam logic [7:0]        c_timeout = 8'(TIMEOUT);
  localparam logic [DATA_W-1:0] c_zero    = {DATA_W{1'b0}};

  logic [1:0]        state_q, state_d;
  logic              op_q, op_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              win_q, win_d;     // 0 = A, 1 = B
  logic              last_q, last_d;   // last granted requester, 0 = A, 1 = B
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        err_q, err_d;

  logic              gnt_a, gnt_b;
  logic              sel_op;
  logic [DATA_W-1:0] sel_wdata;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (state_q == c_st_idle && !rst) begin
      if (reqa_valid && (!reqb_valid || last_q)) begin
        gnt_a = 1'b1;
      end else if (reqb_valid) begin
        gnt_b = 1'b1;
      end
    end
  end

  assign sel_op    = gnt_b ? reqb_op    : reqa_op;
  assign sel_wdata = gnt_b ? reqb_wdata : reqa_wdata;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    win_d   = win_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      c_st_idle: begin
        if (gnt_a || gnt_b) begin
          op_d    = sel_op;
          wdata_d = sel_wdata;
          win_d   = gnt_b;
          last_d  = gnt_b;
          if (sel_op && stk_full) begin
            err_d   = c_err_full;
            rdata_d = c_zero;
            state_d = c_st_resp;
          end else if (!sel_op && stk_empty) begin
            err_d   = c_err_empty;
            rdata_d = c_zero;
            state_d = c_st_resp;
          end else begin
            state_d = c_st_issue;
          end
        end
      end

      c_st_issue: begin
        cnt_d   = 8'd0;
        state_d = c_st_wait;
      end

      c_st_wait: begin
        cnt_d = cnt_q + 8'd1;
        if (stk_done) begin
          err_d   = c_err_ok;
          rdata_d = op_q ? c_zero : stk_rdata;
          state_d = c_st_resp;
        end else if (cnt_d == c_timeout) begin
          err_d   = c_err_timeout;
          rdata_d = c_zero;
          state_d = c_st_resp;
        end
      end

      c_st_resp: begin
        state_d = c_st_idle;
      end

      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_st_idle;
      op_q    <= 1'b0;
      wdata_q <= c_zero;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
      rdata_q <= c_zero;
      err_q   <= c_err_ok;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      win_q   <= win_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign reqa_gnt    = gnt_a;
  assign reqb_gnt    = gnt_b;
  assign respa_valid = (state_q == c_st_resp) && !win_q;
  assign respb_valid = (state_q == c_st_resp) &&  win_q;
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;
  assign stk_push    = (state_q == c_st_issue) &&  op_q;
  assign stk_pop     = (state_q == c_st_issue) && !op_q;
  // Data bus is only driven while a stack command is in flight.
  assign stk_wdata   = (state_q == c_st_issue || state_q == c_st_wait) ? wdata_q : c_zero;

endmodule
`default_nettype wire

// File: tb/tb_stack_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_arbiter
// Purpose  : Self-checking bench for stack_arbiter with a transaction-level
//            model, a small stack emulator and directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stack_arbiter;

  localparam int DW = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          reqa_valid = 1'b0, reqa_op = 1'b0;
  logic [DW-1:0] reqa_wdata = '0;
  logic          reqb_valid = 1'b0, reqb_op = 1'b0;
  logic [DW-1:0] reqb_wdata = '0;
  logic          reqa_gnt, respa_valid, reqb_gnt, respb_valid;
  logic [DW-1:0] resp_rdata;
  logic [1:0]    resp_err;
  logic          stk_push, stk_pop;
  logic [DW-1:0] stk_wdata;
  logic [DW-1:0] stk_rdata = '0;
  logic          stk_done = 1'b0, stk_empty = 1'b1, stk_full = 1'b0;

  stack_arbiter #(.DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .reqa_valid(reqa_valid), .reqa_op(reqa_op), .reqa_wdata(reqa_wdata),
    .reqa_gnt(reqa_gnt), .respa_valid(respa_valid),
    .reqb_valid(reqb_valid), .reqb_op(reqb_op), .reqb_wdata(reqb_wdata),
    .reqb_gnt(reqb_gnt), .respb_valid(respb_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata),
    .stk_rdata(stk_rdata), .stk_done(stk_done),
    .stk_empty(stk_empty), .stk_full(stk_full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- stack emulator ----------------
  logic [DW-1:0] mem [32];
  int sp = 0;
  int done_dly = 1;   // 0 = never complete
  int pending = 0;
  bit force_empty = 0, force_full = 0;

  initial forever begin
    @(negedge clk);
    if (stk_push === 1'b1) begin
      if (sp < 32) begin mem[sp] = stk_wdata; sp++; end
      pending = done_dly;
    end else if (stk_pop === 1'b1) begin
      if (sp > 0) begin sp--; stk_rdata = mem[sp]; end
      pending = done_dly;
    end
    @(posedge clk); #1;
    stk_done = 1'b0;
    if (pending > 0) begin
      pending--;
      if (pending == 0) stk_done = 1'b1;
    end
    stk_empty = (sp == 0) || force_empty;
    stk_full  = (sp == 32) || force_full;
  end

  // ---------------- transaction model + logs ----------------
  int            g_who[$], g_cyc[$], r_who[$], r_cyc[$];
  logic [DW-1:0] r_dat[$], p_dat[$];
  logic [1:0]    r_err[$];
  int            n_pop = 0;

  bit            m_on = 0, m_busy = 0, m_last = 1, m_win = 0, m_op = 0, m_legal = 0;
  bit            m_rknown = 1, m_res_known = 1;
  logic [DW-1:0] m_data = '0, m_popped = '0, m_res_data = '0, m_hold_d = '0;
  logic [1:0]    m_res_err = '0, m_hold_e = '0;
  int            m_t0 = 0, m_rc = -1;
  logic [DW-1:0] m_q[$];

  initial forever begin
    bit e_ga, e_gb, e_push, e_pop, e_ra, e_rb;
    int n;
    @(negedge clk);
    n = cyc;
    e_ga = !m_busy && !rst && reqa_valid && (!reqb_valid || m_last);
    e_gb = !m_busy && !rst && reqb_valid && !e_ga;
    if (m_on) begin
      if (m_busy && n == m_rc) begin
        m_hold_d = m_res_data;
        m_hold_e = m_res_err;
        m_rknown = m_res_known;
      end
      e_push = m_busy && m_legal && n == m_t0 + 1 &&  m_op;
      e_pop  = m_busy && m_legal && n == m_t0 + 1 && !m_op;
      e_ra   = m_busy && n == m_rc && !m_win;
      e_rb   = m_busy && n == m_rc &&  m_win;
      chk("reqa_gnt", reqa_gnt, e_ga);
      chk("reqb_gnt", reqb_gnt, e_gb);
      chk("single_gnt", reqa_gnt & reqb_gnt, 0);
      chk("stk_push", stk_push, e_push);
      chk("stk_pop", stk_pop, e_pop);
      chk("respa_valid", respa_valid, e_ra);
      chk("respb_valid", respb_valid, e_rb);
      chk("resp_err", resp_err, m_hold_e);
      if (m_rknown) chk("resp_rdata", resp_rdata, m_hold_d);
      if (e_push) chk("stk_wdata", stk_wdata, m_data);
    end
    if (reqa_gnt === 1'b1) begin g_who.push_back(0); g_cyc.push_back(n); end
    if (reqb_gnt === 1'b1) begin g_who.push_back(1); g_cyc.push_back(n); end
    if (respa_valid === 1'b1 || respb_valid === 1'b1) begin
      r_who.push_back(respb_valid ? 1 : 0);
      r_cyc.push_back(n);
      r_dat.push_back(resp_rdata);
      r_err.push_back(resp_err);
    end
    if (stk_push === 1'b1) p_dat.push_back(stk_wdata);
    if (stk_pop === 1'b1) n_pop++;

    // advance the model across the coming edge
    if (rst) begin
      m_busy = 0; m_last = 1; m_hold_d = '0; m_hold_e = '0; m_rknown = 1; m_rc = -1;
      m_on = 1;
    end else if (m_busy && n == m_rc) begin
      m_busy = 0;
    end else if (m_busy && m_legal && m_rc < 0) begin
      if (n >= m_t0 + 2 && stk_done) begin
        m_rc = n + 1; m_res_err = 2'b00; m_res_known = 1;
        m_res_data = m_op ? '0 : m_popped;
      end else if (n == m_t0 + 1 + TO) begin
        m_rc = n + 1; m_res_err = 2'b11; m_res_data = '0; m_res_known = 1;
      end
    end else if (!m_busy && (e_ga || e_gb)) begin
      m_busy = 1; m_win = e_gb; m_last = e_gb; m_t0 = n;
      m_op   = e_gb ? reqb_op : reqa_op;
      m_data = e_gb ? reqb_wdata : reqa_wdata;
      m_legal = m_op ? !stk_full : !stk_empty;
      if (m_legal) begin
        m_rc = -1;
        if (m_op) m_q.push_back(m_data);
        else m_popped = (m_q.size() > 0) ? m_q.pop_back() : '0;
      end else begin
        m_rc = n + 1; m_res_err = m_op ? 2'b01 : 2'b10; m_res_data = '0; m_res_known = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic set_req(input bit who, input bit v, input bit op, input logic [DW-1:0] d);
    if (who) begin reqb_valid = v; reqb_op = op; reqb_wdata = d; end
    else     begin reqa_valid = v; reqa_op = op; reqa_wdata = d; end
  endtask

  task automatic do_req(input bit who, input bit op, input logic [DW-1:0] d,
                        output int lat, output int idx);
    bit got;
    int t0;
    idx = r_cyc.size();
    lat = -1;
    t0  = 0;
    set_req(who, 1'b1, op, d);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((who ? reqb_gnt : reqa_gnt) === 1'b1) begin got = 1; t0 = cyc; end
      tick();
    end
    set_req(who, 1'b0, 1'b0, '0);
    if (!got) begin
      chk("gnt_wait", 0, 1);
      return;
    end
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk); #1;
      if (r_cyc.size() > idx) got = 1;
      else tick();
    end
    tick();
    if (!got) chk("resp_wait", 0, 1);
    else lat = r_cyc[idx] - t0;
  endtask

  initial begin
    int lat, k, base, np, nr;
    bit done;

    // reset
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_gnt", {reqa_gnt, reqb_gnt}, 0);
    chk("rst_resp", {respa_valid, respb_valid}, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_cmd", {stk_push, stk_pop}, 0);
    chk("rst_wdata", stk_wdata, 0);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("idle_gnt", {reqa_gnt, reqb_gnt}, 0);
    tick();

    // A pushes 0x5A, B pops it back
    done_dly = 1;
    do_req(0, 1, 8'h5A, lat, k);
    chk("a_push_lat", lat, 3);
    if (lat >= 0) begin
      chk("a_push_who", r_who[k], 0);
      chk("a_push_err", r_err[k], 2'b00);
    end
    chk("a_push_bus", (p_dat.size() > 0) ? p_dat[p_dat.size()-1] : 8'hxx, 8'h5A);
    np = n_pop;
    do_req(1, 0, 8'h00, lat, k);
    chk("b_pop_lat", lat, 3);
    if (lat >= 0) begin
      chk("b_pop_who", r_who[k], 1);
      chk("b_pop_rdata", r_dat[k], 8'h5A);
      chk("b_pop_err", r_err[k], 2'b00);
    end
    chk("b_pop_cmd", n_pop - np, 1);

    // both requesters valid continuously
    base = g_who.size();
    nr   = r_cyc.size();
    set_req(0, 1'b1, 1'b1, 8'h11);
    set_req(1, 1'b1, 1'b1, 8'h22);
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk); #1;
      if (g_who.size() >= base + 4) done = 1;
      tick();
    end
    set_req(0, 1'b0, 1'b0, '0);
    set_req(1, 1'b0, 1'b0, '0);
    chk("rr_grants", done, 1);
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk); #1;
      if (r_cyc.size() >= nr + 4) done = 1;
      tick();
    end
    chk("rr_resps", done, 1);
    if (g_who.size() >= base + 4) begin
      chk("rr_order", {g_who[base][3:0], g_who[base+1][3:0], g_who[base+2][3:0], g_who[base+3][3:0]},
          32'h0101);
      chk("rr_spacing", g_cyc[base+1] - g_cyc[base], 4);
    end

    // illegal requests
    force_empty = 1; tick(); tick();
    np = n_pop;
    do_req(0, 0, 8'h00, lat, k);
    chk("empty_lat", lat, 1);
    if (lat >= 0) chk("empty_err", r_err[k], 2'b10);
    chk("empty_no_pop", n_pop - np, 0);
    force_empty = 0; force_full = 1; tick(); tick();
    np = p_dat.size();
    do_req(1, 1, 8'h44, lat, k);
    chk("full_lat", lat, 1);
    if (lat >= 0) chk("full_err", r_err[k], 2'b01);
    chk("full_no_push", p_dat.size() - np, 0);
    force_full = 0; tick(); tick();

    // timeout, then a normal request
    done_dly = 0;
    do_req(0, 1, 8'h77, lat, k);
    chk("to_lat", lat, TO + 2);
    if (lat >= 0) begin
      chk("to_err", r_err[k], 2'b11);
      chk("to_rdata", r_dat[k], 8'h00);
    end
    done_dly = 1;
    do_req(1, 0, 8'h00, lat, k);
    chk("after_to_lat", lat, 3);
    if (lat >= 0) begin
      chk("after_to_err", r_err[k], 2'b00);
      chk("after_to_rdata", r_dat[k], 8'h77);
    end

    // reset while waiting on the stack
    done_dly = 0;
    nr = r_cyc.size();
    set_req(1, 1'b1, 1'b1, 8'h33);
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (reqb_gnt === 1'b1) done = 1;
      tick();
    end
    set_req(1, 1'b0, 1'b0, '0);
    chk("rw_gnt", done, 1);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("rw_no_resp", r_cyc.size() - nr, 0);
    done_dly = 1;
    set_req(0, 1'b1, 1'b1, 8'h66);
    set_req(1, 1'b1, 1'b1, 8'h99);
    @(negedge clk);
    chk("rw_first_a", {reqa_gnt, reqb_gnt}, 2'b10);
    tick();
    set_req(0, 1'b0, 1'b0, '0);
    set_req(1, 1'b0, 1'b0, '0);
    repeat (6) tick();
    chk("rw_resp_a", (r_who.size() > nr) ? r_who[r_who.size()-1] : -1, 0);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
